// File: rtl/mmio_regfile_pkg.sv
// Shared types for the MMIO register-file AFU: a minimal CCI-P subset, register map
// indices and the read-response pipeline entry.
package mmio_regfile_pkg;

   typedef logic [8:0] t_ccip_tid;

   typedef struct packed {
      logic [15:0] address;
      logic [1:0]  length;
      logic        rsvd;
      t_ccip_tid   tid;
   } t_ccip_c0_ReqMmioHdr;

   // c0 header arrives as a raw vector and is reinterpreted as an MMIO header on decode
   typedef logic [$bits(t_ccip_c0_ReqMmioHdr)-1:0] t_ccip_c0_RxHdr;

   typedef struct packed {
      t_ccip_c0_RxHdr hdr;
      logic [511:0]   data;
      logic           rspValid;
      logic           mmioRdValid;
      logic           mmioWrValid;
   } t_if_ccip_c0_Rx;

   typedef struct packed {
      logic           c0TxAlmFull;
      logic           c1TxAlmFull;
      t_if_ccip_c0_Rx c0;
   } t_if_ccip_Rx;

   typedef struct packed {
      logic [73:0] hdr;
      logic        valid;
   } t_if_ccip_c0_Tx;

   typedef struct packed {
      logic [79:0]  hdr;
      logic [511:0] data;
      logic         valid;
   } t_if_ccip_c1_Tx;

   typedef struct packed {
      t_ccip_tid tid;
   } t_ccip_c2_RspMmioHdr;

   typedef struct packed {
      t_ccip_c2_RspMmioHdr hdr;
      logic                mmioRdValid;
      logic [63:0]         data;
   } t_if_ccip_c2_Tx;

   typedef struct packed {
      t_if_ccip_c0_Tx c0;
      t_if_ccip_c1_Tx c1;
      t_if_ccip_c2_Tx c2;
   } t_if_ccip_Tx;

   localparam logic [1:0] LEN_32 = 2'b00;
   localparam logic [1:0] LEN_64 = 2'b01;

   localparam int unsigned IDX_DFH      = 0;
   localparam int unsigned IDX_AFUID_LO = 1;
   localparam int unsigned IDX_AFUID_HI = 2;
   localparam int unsigned IDX_ERR_CNT  = 3;
   localparam int unsigned IDX_WR_CNT   = 4;
   localparam int unsigned IDX_RD_CNT   = 5;
   localparam int unsigned IDX_SCRATCH0 = 6;

   localparam logic [63:0] ERR_DATA = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef struct packed {
      logic        valid;
      t_ccip_tid   tid;
      logic [63:0] data;
   } t_mmio_rsp;

endpackage

// File: rtl/ccip_mmio_regfile_afu_if.sv
// CCI-P receive/transmit bundle; master is the host/FIU side, slave is the AFU.
interface ccip_mmio_regfile_afu_if;
   import mmio_regfile_pkg::*;

   t_if_ccip_Rx pck_cp2af_sRx;
   t_if_ccip_Tx pck_af2cp_sTx;

   modport master (output pck_cp2af_sRx, input pck_af2cp_sTx);
   modport slave (input pck_cp2af_sRx, output pck_af2cp_sTx);

endinterface

// File: rtl/mmio_rd_pipe.sv
// Fixed-latency, order-preserving shift pipeline for MMIO read responses.
module mmio_rd_pipe
   import mmio_regfile_pkg::*;
#(
   parameter int unsigned RD_LATENCY = 2
) (
   input  logic      i_clk,
   input  logic      i_rst,
   input  t_mmio_rsp i_rsp,
   output t_mmio_rsp o_rsp
);

   t_mmio_rsp r_stage [RD_LATENCY];

   // Reset clears every stage so no stale response escapes after a flush
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < int'(RD_LATENCY); i++) begin
            r_stage[i] <= '0;
         end
      end else begin
         r_stage[0] <= i_rsp;
         for (int i = 1; i < int'(RD_LATENCY); i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign o_rsp = r_stage[RD_LATENCY-1];

endmodule

// File: rtl/ccip_mmio_regfile_afu.sv
// MMIO register-file AFU: header/statistics registers, scratch storage and a
// fixed-latency read-response path onto CCI-P c2.
module ccip_mmio_regfile_afu
   import mmio_regfile_pkg::*;
#(
   parameter int unsigned NUM_REGS   = 64,
   parameter int unsigned RD_LATENCY = 2,
   parameter logic [63:0] AFUID_LO   = 64'h96bf6f5fc4038fac,
   parameter logic [63:0] AFUID_HI   = 64'h10c1bff188d14dfb,
   parameter logic [63:0] DFH_VALUE  = 64'h1000_0000_0000_1000
) (
   input logic                    pClk,
   input logic                    pck_cp2af_softReset,
   ccip_mmio_regfile_afu_if.slave ccip
);

   localparam int unsigned IDX_W = $clog2(NUM_REGS);

   t_if_ccip_c0_Rx      w_c0;
   t_ccip_c0_ReqMmioHdr w_hdr;
   logic [15:0]         w_dw;
   logic [14:0]         w_qw;
   logic [IDX_W-1:0]    w_idx;
   logic                w_out_of_range;
   logic                w_len64;
   logic                w_bad_len;
   logic                w_misaligned;
   logic                w_err;
   logic                w_hi_half;
   logic                w_wr;
   logic                w_rd;
   logic                w_wr_ok;
   logic                w_rd_ok;
   logic                w_scratch_hit;
   logic [63:0]         w_reg;
   logic [63:0]         w_sel;
   t_mmio_rsp           w_rsp_in;
   t_mmio_rsp           w_rsp_out;
   logic                w_unused_rx;

   logic [63:0] r_scratch [NUM_REGS];
   logic [63:0] r_err_cnt;
   logic [63:0] r_wr_cnt;
   logic [63:0] r_rd_cnt;

   assign w_c0  = ccip.pck_cp2af_sRx.c0;
   assign w_hdr = t_ccip_c0_ReqMmioHdr'(w_c0.hdr);
   assign w_dw  = w_hdr.address;
   assign w_qw  = w_dw[15:1];
   assign w_idx = w_qw[IDX_W-1:0];

   assign w_out_of_range = (32'(w_qw) >= NUM_REGS);
   assign w_len64        = (w_hdr.length == LEN_64);
   assign w_bad_len      = w_hdr.length[1];
   assign w_misaligned   = w_len64 & w_dw[0];
   assign w_err          = w_out_of_range | w_misaligned | w_bad_len;
   assign w_hi_half      = w_dw[0];
   assign w_scratch_hit  = (32'(w_idx) >= IDX_SCRATCH0);

   // A simultaneous read is dropped entirely when a write is present
   assign w_wr    = w_c0.mmioWrValid;
   assign w_rd    = w_c0.mmioRdValid & ~w_c0.mmioWrValid;
   assign w_wr_ok = w_wr & ~w_err;
   assign w_rd_ok = w_rd & ~w_err;

   always_ff @(posedge pClk) begin
      if (pck_cp2af_softReset) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            r_scratch[i] <= '0;
         end
      end else if (w_wr_ok && w_scratch_hit) begin
         if (w_len64) begin
            r_scratch[w_idx] <= w_c0.data[63:0];
         end else if (w_hi_half) begin
            r_scratch[w_idx][63:32] <= w_c0.data[31:0];
         end else begin
            r_scratch[w_idx][31:0] <= w_c0.data[31:0];
         end
      end
   end

   always_ff @(posedge pClk) begin
      if (pck_cp2af_softReset) begin
         r_err_cnt <= '0;
         r_wr_cnt  <= '0;
         r_rd_cnt  <= '0;
      end else begin
         if ((w_wr || w_rd) && w_err) begin
            r_err_cnt <= r_err_cnt + 64'd1;
         end
         if (w_wr_ok) begin
            r_wr_cnt <= r_wr_cnt + 64'd1;
         end
         if (w_rd_ok) begin
            r_rd_cnt <= r_rd_cnt + 64'd1;
         end
      end
   end

   // Read data comes from pre-edge state, so a write one cycle earlier is already visible
   always_comb begin
      w_reg = '0;
      case (32'(w_idx))
         IDX_DFH:      w_reg = DFH_VALUE;
         IDX_AFUID_LO: w_reg = AFUID_LO;
         IDX_AFUID_HI: w_reg = AFUID_HI;
         IDX_ERR_CNT:  w_reg = r_err_cnt;
         IDX_WR_CNT:   w_reg = r_wr_cnt;
         IDX_RD_CNT:   w_reg = r_rd_cnt;
         default:      w_reg = r_scratch[w_idx];
      endcase
   end

   always_comb begin
      w_sel = w_reg;
      if (!w_len64) begin
         w_sel = {32'h0, (w_hi_half ? w_reg[63:32] : w_reg[31:0])};
      end
      w_rsp_in       = '0;
      w_rsp_in.valid = w_rd;
      w_rsp_in.tid   = w_hdr.tid;
      w_rsp_in.data  = w_err ? ERR_DATA : w_sel;
   end

   mmio_rd_pipe #(
      .RD_LATENCY (RD_LATENCY)
   ) u_rd_pipe (
      .i_clk (pClk),
      .i_rst (pck_cp2af_softReset),
      .i_rsp (w_rsp_in),
      .o_rsp (w_rsp_out)
   );

   always_comb begin
      ccip.pck_af2cp_sTx                = '0;
      ccip.pck_af2cp_sTx.c2.mmioRdValid = w_rsp_out.valid;
      ccip.pck_af2cp_sTx.c2.hdr.tid     = w_rsp_out.tid;
      ccip.pck_af2cp_sTx.c2.data        = w_rsp_out.data;
   end

   assign w_unused_rx = ^{ccip.pck_cp2af_sRx.c0TxAlmFull, ccip.pck_cp2af_sRx.c1TxAlmFull,
                          w_c0.rspValid, w_c0.data[511:64], w_hdr.rsvd};

endmodule
